// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative floating-point divider.
package fp_div_pkg;

  typedef enum logic [2:0] {StIdle, StUnpack, StIter, StRound, StDone} state_e;

  typedef enum logic [2:0] {
    ClsZero, ClsSubnormal, ClsNormal, ClsInf, ClsQnan, ClsSnan
  } op_class_e;

  localparam logic RndRne = 1'b0;
  localparam logic RndRtz = 1'b1;

  // Canonical quiet NaN: positive sign, all-ones exponent, only the quiet bit set.
  function automatic logic [63:0] canon_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mant_div_core.sv
// Restoring mantissa divider, one quotient bit per cycle; the first bit is produced on start.
module fp_mant_div_core
  import fp_div_pkg::*;
#(
  parameter int unsigned MAN_W = 23
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAN_W+1:0] ma,
  input  logic [MAN_W:0]   mb,
  output logic [MAN_W+1:0] q,
  output logic             sticky,
  output logic             done
);

  localparam int unsigned CntW = $clog2(MAN_W + 3);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAN_W + 1);

  logic [MAN_W+1:0] r_q, r_cur, r_keep, r_nxt;
  logic [MAN_W:0]   mb_q, mb_cur;
  logic [MAN_W+2:0] diff;
  logic [CntW-1:0]  cnt_q;
  logic             run_q, q_bit;

  always_comb begin
    r_cur  = start ? ma : r_q;
    mb_cur = start ? mb : mb_q;
    diff   = {1'b0, r_cur} - {2'b00, mb_cur};
    q_bit  = ~diff[MAN_W+2];
    r_keep = q_bit ? diff[MAN_W+1:0] : r_cur;
    // Partial remainder stays below mb, so the top bit is always zero before the shift.
    r_nxt  = {r_keep[MAN_W:0], 1'b0};
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      mb_q  <= '0;
      q     <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      r_q   <= r_nxt;
      mb_q  <= mb;
      q     <= {{(MAN_W + 1){1'b0}}, q_bit};
      cnt_q <= CntW'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      r_q   <= r_nxt;
      q     <= {q[MAN_W:0], q_bit};
      cnt_q <= cnt_q + CntW'(1);
      if (cnt_q == LastCnt) run_q <= 1'b0;
    end
  end

  assign done   = run_q && (cnt_q == LastCnt);
  assign sticky = (r_q != '0);

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider: unpack/classify, iterative mantissa divide, RNE/RTZ rounding.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned XLEN = EXP_W + MAN_W + 1
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            data_valid,
  input  logic            rnd_rtz,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            data_ready,
  output logic [XLEN-1:0] quotient_o,
  output logic            divided_by_zero,
  output logic            invalid,
  output logic            overflow,
  output logic            underflow,
  output logic            inexact
);

  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] Bias = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMax = EW'((1 << EXP_W) - 1);
  localparam logic [XLEN-1:0] QNaN = XLEN'(canon_qnan(EXP_W, MAN_W));

  state_e                state_q;
  logic [XLEN-1:0]       a_q, b_q;
  logic                  rtz_q, sign_q;
  logic signed [EW-1:0]  e_q;

  function automatic op_class_e classify(input logic [XLEN-1:0] x);
    if (x[XLEN-2:MAN_W] == '0) return (x[MAN_W-1:0] == '0) ? ClsZero : ClsSubnormal;
    if (x[XLEN-2:MAN_W] == '1) begin
      if (x[MAN_W-1:0] == '0) return ClsInf;
      return x[MAN_W-1] ? ClsQnan : ClsSnan;
    end
    return ClsNormal;
  endfunction

  op_class_e            cls_a, cls_b;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_snan;
  logic                 special, sign, adj, spec_inv, spec_dbz;
  logic [MAN_W:0]       ma_raw, mb;
  logic [MAN_W+1:0]     ma;
  logic signed [EW-1:0] e_unp;
  logic [XLEN-1:0]      spec_res;

  always_comb begin
    cls_a    = classify(a_q);
    cls_b    = classify(b_q);
    a_zero   = cls_a inside {ClsZero, ClsSubnormal};
    b_zero   = cls_b inside {ClsZero, ClsSubnormal};
    a_inf    = (cls_a == ClsInf);
    b_inf    = (cls_b == ClsInf);
    a_nan    = cls_a inside {ClsQnan, ClsSnan};
    b_nan    = cls_b inside {ClsQnan, ClsSnan};
    any_snan = (cls_a == ClsSnan) || (cls_b == ClsSnan);
    sign     = a_q[XLEN-1] ^ b_q[XLEN-1];
    special  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    ma_raw   = {1'b1, a_q[MAN_W-1:0]};
    mb       = {1'b1, b_q[MAN_W-1:0]};
    // Pre-shift the dividend so the quotient always lands in [1,2).
    adj      = (ma_raw < mb);
    ma       = adj ? {ma_raw, 1'b0} : {1'b0, ma_raw};
    e_unp    = EW'(a_q[XLEN-2:MAN_W]) - EW'(b_q[XLEN-2:MAN_W]) + Bias - EW'(adj);

    spec_res = {sign, {(XLEN - 1){1'b0}}};
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan | b_nan) begin
      spec_res = QNaN;
      spec_inv = any_snan;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_res = QNaN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_dbz = 1'b1;
    end
  end

  logic             core_start, core_done, sticky;
  logic [MAN_W+1:0] q_core;

  assign core_start = (state_q == StUnpack) && !special;

  fp_mant_div_core #(.MAN_W(MAN_W)) u_core (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .start  (core_start),
    .ma     (ma),
    .mb     (mb),
    .q      (q_core),
    .sticky (sticky),
    .done   (core_done)
  );

  logic [MAN_W:0]       mant;
  logic [MAN_W+1:0]     mant_sum;
  logic                 guard, rnd_inc, rnd_ovf, rnd_unf, rnd_inx;
  logic signed [EW-1:0] e_rnd;
  logic [XLEN-1:0]      rnd_res;

  always_comb begin
    guard    = q_core[0];
    mant     = q_core[MAN_W+1:1];
    rnd_inc  = (rtz_q == RndRne) & guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + (MAN_W + 2)'(rnd_inc);
    // A carry-out leaves the fraction field all zeros, i.e. mantissa 1.0 at e+1.
    e_rnd    = e_q + EW'(mant_sum[MAN_W+1]);
    rnd_inx  = guard | sticky;
    rnd_ovf  = 1'b0;
    rnd_unf  = 1'b0;
    rnd_res  = {sign_q, e_rnd[EXP_W-1:0], mant_sum[MAN_W-1:0]};
    if (e_rnd >= EMax) begin
      rnd_ovf = 1'b1;
      rnd_inx = 1'b1;
      rnd_res = (rtz_q == RndRtz) ? {sign_q, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                  : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_rnd <= 0) begin
      rnd_unf = 1'b1;
      rnd_inx = 1'b1;
      rnd_res = {sign_q, {(XLEN - 1){1'b0}}};
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      a_q             <= '0;
      b_q             <= '0;
      rtz_q           <= 1'b0;
      sign_q          <= 1'b0;
      e_q             <= '0;
      busy            <= 1'b0;
      data_ready      <= 1'b0;
      quotient_o      <= '0;
      divided_by_zero <= 1'b0;
      invalid         <= 1'b0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      inexact         <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (data_valid) begin
            state_q         <= StUnpack;
            a_q             <= dividend;
            b_q             <= divisor;
            rtz_q           <= rnd_rtz;
            busy            <= 1'b1;
            divided_by_zero <= 1'b0;
            invalid         <= 1'b0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
            inexact         <= 1'b0;
          end
        end
        StUnpack: begin
          if (special) begin
            state_q         <= StDone;
            quotient_o      <= spec_res;
            invalid         <= spec_inv;
            divided_by_zero <= spec_dbz;
            data_ready      <= 1'b1;
            busy            <= 1'b0;
          end else begin
            state_q <= StIter;
            sign_q  <= sign;
            e_q     <= e_unp;
          end
        end
        StIter: if (core_done) state_q <= StRound;
        StRound: begin
          state_q    <= StDone;
          quotient_o <= rnd_res;
          overflow   <= rnd_ovf;
          underflow  <= rnd_unf;
          inexact    <= rnd_inx;
          data_ready <= 1'b1;
          busy       <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
